// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC model.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_adc_mc_if.sv
// Request/result bundle between the analog front-end models and the ADC.
interface sar_adc_mc_if
    import sar_adc_pkg::*;
#(
    parameter int unsigned bits     = 8,
    parameter int unsigned channels = 4,
    parameter int unsigned CW       = ch_width(channels)
);
    real             in [channels];
    logic            start;
    logic [CW-1:0]   ch_sel;
    logic            scan;
    logic            busy;
    logic            valid;
    logic [bits-1:0] out;
    logic [CW-1:0]   out_ch;
    logic            over;
    logic            under;
    logic            err;

    modport master (
        output in, start, ch_sel, scan,
        input  busy, valid, out, out_ch, over, under, err
    );

    modport slave (
        input  in, start, ch_sel, scan,
        output busy, valid, out, out_ch, over, under, err
    );
endinterface

// File: rtl/sar_adc_mc_core.sv
// One successive-approximation conversion: residue, bit pointer and result shadow.
module sar_core
    import sar_adc_pkg::*;
#(
    parameter int unsigned bits      = 8,
    parameter real         fullscale = 1.0,
    parameter int unsigned KW        = ch_width(bits)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  real             sample,
    input  logic            step,
    output logic [KW-1:0]   bits_left,
    output logic [bits-1:0] code
);
    localparam real half = fullscale / 2.0;

    real             residue;
    logic [KW-1:0]   k;
    logic [bits-1:0] shadow;
    logic            d_c;

    // Strict compare: exactly half-scale resolves to 0.
    assign d_c       = (residue > half);
    assign bits_left = k;
    assign code      = shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            residue <= 0.0;
            k       <= '0;
            shadow  <= '0;
        end else if (load) begin
            residue <= sample;
            k       <= KW'(bits - 1);
        end else if (step) begin
            shadow[k] <= d_c;
            residue   <= (d_c ? (residue - half) : residue) * 2.0;
            if (k != '0) begin
                k <= k - 1'b1;
            end
        end
    end
endmodule

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC: channel mux, round-robin scan, range flags and result registers.
module sar_adc_mc
    import sar_adc_pkg::*;
#(
    parameter int unsigned bits      = 8,
    parameter int unsigned channels  = 4,
    parameter real         fullscale = 1.0,
    parameter int unsigned CW        = ch_width(channels)
) (
    input  logic         clk,
    input  logic         rst,
    sar_adc_mc_if.slave  bus
);
    localparam int unsigned KW = ch_width(bits);

    state_t          state;
    state_t          nxt_state;
    logic            load_c;
    logic            step_c;
    logic [CW-1:0]   sel_c;
    logic [CW-1:0]   nxt_ch_c;
    logic            legal_c;
    logic [CW-1:0]   cur_ch;
    logic            ovr_q;
    logic            und_q;
    real             sample_c;
    logic [KW-1:0]   k;
    logic [bits-1:0] code;

    assign legal_c  = (32'(bus.ch_sel) < 32'(channels));
    assign nxt_ch_c = ((32'(cur_ch) + 32'd1) >= 32'(channels)) ? '0
                                                                : CW'(32'(cur_ch) + 32'd1);
    assign sample_c = bus.in[sel_c];

    sar_core #(
        .bits      (bits),
        .fullscale (fullscale),
        .KW        (KW)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .sample    (sample_c),
        .step      (step_c),
        .bits_left (k),
        .code      (code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next state plus core load/step; DONE with scan reloads the next channel directly.
    always_comb begin
        nxt_state = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        sel_c     = bus.ch_sel;
        case (state)
            IDLE: begin
                if (bus.start && legal_c) begin
                    load_c    = 1'b1;
                    nxt_state = CONV;
                end
            end
            CONV: begin
                step_c = 1'b1;
                if (k == '0) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                if (bus.scan) begin
                    load_c    = 1'b1;
                    sel_c     = nxt_ch_c;
                    nxt_state = CONV;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Range flags are captured with the sample and published alongside the code.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch     <= '0;
            ovr_q      <= 1'b0;
            und_q      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.valid  <= 1'b0;
            bus.out    <= '0;
            bus.out_ch <= '0;
            bus.over   <= 1'b0;
            bus.under  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= (nxt_state != IDLE);
            if (load_c) begin
                cur_ch <= sel_c;
                ovr_q  <= (sample_c > fullscale);
                und_q  <= (sample_c < 0.0);
            end
            if ((state == IDLE) && bus.start && !legal_c) begin
                bus.err <= 1'b1;
            end
            if (state == DONE) begin
                bus.out    <= code;
                bus.out_ch <= cur_ch;
                bus.over   <= ovr_q;
                bus.under  <= und_q;
                bus.valid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sar_adc_mc.sv
// Directed bench for sar_adc_mc: single conversions, range flags, scan, illegal channel, reset abort.
module tb_sar_adc_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_adc_mc_if #(.bits(8), .channels(4), .CW(2)) u_if ();
    sar_adc_mc_if #(.bits(8), .channels(5), .CW(3)) u_if5 ();

    sar_adc_mc #(.bits(8), .channels(4), .fullscale(1.0), .CW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    sar_adc_mc #(.bits(8), .channels(5), .fullscale(1.0), .CW(3)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (u_if5.slave)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic start_conv(input int ch, input real v);
        @(negedge clk);
        u_if.in[ch]  = v;
        u_if.ch_sel  = 2'(ch);
        u_if.start   = 1'b1;
        @(negedge clk);
        u_if.start   = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (u_if.valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (u_if.valid === 1'b1) nv++;
        end
    endtask

    task automatic conv_check(input string tag, input int ch, input real v,
                              input logic [7:0] exp_out, input logic exp_over,
                              input logic exp_under);
        int lat;
        start_conv(ch, v);
        wait_valid(lat);
        chk({tag, "_lat"},   lat, 9);
        chk({tag, "_out"},   u_if.out, exp_out);
        chk({tag, "_ch"},    u_if.out_ch, ch);
        chk({tag, "_over"},  u_if.over, exp_over);
        chk({tag, "_under"}, u_if.under, exp_under);
        chk({tag, "_busy"},  u_if.busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, u_if.valid, 0);
    endtask

    initial begin
        int lat;
        int nv;
        logic busy_ok;
        logic [7:0] exp_code [4];
        int exp_ch [4];

        u_if.start   = 1'b0;
        u_if.ch_sel  = '0;
        u_if.scan    = 1'b0;
        u_if5.start  = 1'b0;
        u_if5.ch_sel = '0;
        u_if5.scan   = 1'b0;
        for (int i = 0; i < 4; i++) u_if.in[i] = 0.0;
        for (int i = 0; i < 5; i++) u_if5.in[i] = 0.0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  u_if.busy, 0);
        chk("rst_valid", u_if.valid, 0);
        chk("rst_out",   u_if.out, 0);
        chk("rst_err",   u_if.err, 0);
        rst = 1'b0;

        conv_check("c03",   2, 0.3,   8'h4C, 1'b0, 1'b0);
        conv_check("c05",   0, 0.5,   8'h7F, 1'b0, 1'b0);
        conv_check("c075",  0, 0.75,  8'hBF, 1'b0, 1'b0);
        conv_check("c12",   1, 1.2,   8'hFF, 1'b1, 1'b0);
        conv_check("cneg",  1, -0.1,  8'h00, 1'b0, 1'b1);

        // Round-robin scan from channel 3.
        u_if.in[3] = 0.3;   u_if.in[0] = 0.75;  u_if.in[1] = 0.5;   u_if.in[2] = 0.125;
        exp_ch   = '{3, 0, 1, 2};
        exp_code = '{8'h4C, 8'hBF, 8'h7F, 8'h1F};
        u_if.scan = 1'b1;
        start_conv(3, 0.3);
        busy_ok = 1'b1;
        for (int r = 0; r < 4; r++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                if (u_if.busy !== 1'b1 && !(r == 3 && u_if.valid === 1'b1)) busy_ok = 1'b0;
            end while (u_if.valid !== 1'b1 && lat < 40);
            chk($sformatf("scan%0d_lat", r), lat, 9);
            chk($sformatf("scan%0d_out", r), u_if.out, exp_code[r]);
            chk($sformatf("scan%0d_ch", r),  u_if.out_ch, exp_ch[r]);
            if (r == 2) u_if.scan = 1'b0;
        end
        chk("scan_busy_cont", busy_ok, 1);
        chk("scan_end_busy",  u_if.busy, 0);

        // Illegal channel on a 5-channel instance.
        @(negedge clk);
        u_if5.ch_sel = 3'd5;
        u_if5.start  = 1'b1;
        @(negedge clk);
        u_if5.start  = 1'b0;
        chk("err_pulse", u_if5.err, 1);
        chk("err_busy",  u_if5.busy, 0);
        @(negedge clk);
        chk("err_one",   u_if5.err, 0);
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (u_if5.valid === 1'b1) nv++;
        end
        chk("err_novalid", nv, 0);

        // Highest channel of the 5-channel instance is legal.
        u_if5.in[4]  = 0.3;
        u_if5.ch_sel = 3'd4;
        u_if5.start  = 1'b1;
        @(negedge clk);
        u_if5.start  = 1'b0;
        lat = 0;
        while (u_if5.valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ch4_lat", lat, 9);
        chk("ch4_out", u_if5.out, 8'h4C);
        chk("ch4_ch",  u_if5.out_ch, 4);

        // Reset in the middle of a conversion.
        start_conv(2, 0.3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  u_if.busy, 0);
        chk("abort_out",   u_if.out, 0);
        chk("abort_valid", u_if.valid, 0);
        count_valid(15, nv);
        chk("abort_novalid", nv, 0);

        // Fresh conversion with an ignored start while busy.
        start_conv(0, 0.75);
        repeat (3) @(negedge clk);
        u_if.ch_sel = 2'd1;
        u_if.start  = 1'b1;
        @(negedge clk);
        u_if.start  = 1'b0;
        wait_valid(lat);
        chk("fresh_lat", lat, 5);
        chk("fresh_out", u_if.out, 8'hBF);
        chk("fresh_ch",  u_if.out_ch, 0);
        count_valid(15, nv);
        chk("busy_start_novalid", nv, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
